servo_ramp_pwm: RTL and testbench

Per-joint servo driver for the arm system. It consumes one joint's DESIRED position code from the arm sequencer, slews an internal CURRENT position toward it by a bounded step each PWM frame, and generates the servo PWM pulse. It reports a settled FLAG back to the sequencer. One instance is used per joint (claw, upper joint, lower joint), so the arm cannot jump a joint to a new angle in a single frame.

---
 rtl/servo_ramp_pwm_if.sv | 11 +
 rtl/servo_ramp_pwm.sv | 74 +++++++
 tb/tb_servo_ramp_pwm.sv | 114 +++++++++++
 3 files changed

// File: rtl/servo_ramp_pwm_if.sv
// servo_ramp_pwm_if: sequencer-to-joint-driver signal bundle
interface servo_ramp_pwm_if;
    logic        ENABLE;
    logic [19:0] DESIRED;
    logic        PWM;
    logic [19:0] CURRENT;
    logic        FRAME;
    logic        FLAG;
    modport master (output ENABLE, DESIRED, input PWM, CURRENT, FRAME, FLAG);
    modport slave  (input ENABLE, DESIRED, output PWM, CURRENT, FRAME, FLAG);
endinterface

// File: rtl/servo_ramp_pwm.sv
// servo_ramp_pwm: slews a joint position toward its target once per frame and drives the servo pulse
module servo_ramp_pwm #(
    parameter int PERIOD        = 2000000,
    parameter int MIN_PULSE     = 100000,
    parameter int MAX_POS       = 200000,
    parameter int STEP          = 4000,
    parameter int SETTLE_FRAMES = 5,
    parameter int INIT_POS      = 113274
) (
    input logic CLK,
    input logic RST,
    servo_ramp_pwm_if.slave bus
);
    localparam int CW = $clog2(PERIOD);
    typedef enum logic [1:0] {IDLE, RAMP, SETTLE, HOLD} state_t;
    state_t        state;
    logic [CW-1:0] cnt, cnt_d;
    logic [19:0]   cur, tgt, tgt_n, cur_n, cur_d;
    logic [20:0]   wid;
    logic [4:0]    sc, sc_n;
    logic          pwm, flag, bnd, on, restart;
    always_comb begin
        bnd     = bus.ENABLE && cnt == '0;
        tgt_n   = bus.DESIRED > 20'(MAX_POS) ? 20'(MAX_POS) : bus.DESIRED;
        cur_n   = tgt_n > cur ? (tgt_n - cur > 20'(STEP) ? cur + 20'(STEP) : tgt_n)
                              : (cur - tgt_n > 20'(STEP) ? cur - 20'(STEP) : tgt_n);
        cur_d   = bnd ? cur_n : cur;
        cnt_d   = (!bus.ENABLE || cnt == CW'(PERIOD - 1)) ? '0 : cnt + CW'(1);
        wid     = 21'(MIN_PULSE) + {1'b0, cur_d};
        on      = cur_n == tgt_n;
        restart = state inside {IDLE, RAMP} || tgt_n != tgt;
        sc_n    = restart ? 5'd1 : sc + 5'd1;
    end
    // PWM is registered from the next count so the pulse starts the cycle after FRAME
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt   <= '0;
            pwm   <= 1'b0;
            flag  <= 1'b0;
            cur   <= 20'(INIT_POS);
            tgt   <= 20'(INIT_POS);
            sc    <= '0;
            state <= IDLE;
        end else begin
            cnt <= cnt_d;
            pwm <= cnt_d != '0 && 32'(cnt_d) <= 32'(wid);
            if (!bus.ENABLE) begin
                state <= IDLE;
                flag  <= 1'b0;
                sc    <= '0;
            end else if (bnd) begin
                tgt <= tgt_n;
                cur <= cur_n;
                if (!on) begin
                    state <= RAMP;
                    sc    <= '0;
                    flag  <= 1'b0;
                end else if (sc_n >= 5'(SETTLE_FRAMES)) begin
                    state <= HOLD;
                    sc    <= 5'(SETTLE_FRAMES);
                    flag  <= 1'b1;
                end else begin
                    state <= SETTLE;
                    sc    <= sc_n;
                    flag  <= 1'b0;
                end
            end
        end
    end
    assign bus.FRAME   = bnd && !RST;
    assign bus.PWM     = pwm;
    assign bus.CURRENT = cur;
    assign bus.FLAG    = flag;
endmodule

// File: tb/tb_servo_ramp_pwm.sv
// tb_servo_ramp_pwm: directed checks of framing, ramping, clamping, settling, enable and reset
module tb_servo_ramp_pwm;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last = 0;
    servo_ramp_pwm_if bus();
    servo_ramp_pwm #(
        .PERIOD(1000), .MIN_PULSE(100), .MAX_POS(400),
        .STEP(50), .SETTLE_FRAMES(3), .INIT_POS(0)
    ) dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic wait_frame();
        int i = 0;
        while (!bus.FRAME && i < 1100) begin
            @(negedge CLK);
            i++;
        end
        chk("frame_seen", 32'(bus.FRAME), 1);
    endtask
    task automatic frame(input string tag, input int ew, input int ecur, input logic efl, input int eper);
        int w;
        logic [19:0] c;
        logic f;
        wait_frame();
        if (eper > 0) chk({tag, "_period"}, cyc - last, eper);
        last = cyc;
        @(negedge CLK);
        c = bus.CURRENT;
        f = bus.FLAG;
        w = 0;
        while (bus.PWM && w < 1000) begin
            w++;
            @(negedge CLK);
        end
        chk({tag, "_width"}, w, ew);
        chk({tag, "_current"}, 32'(c), ecur);
        chk({tag, "_flag"}, 32'(f), 32'(efl));
    endtask
    initial begin
        int c175[4] = '{50, 100, 150, 175};
        int c400[7] = '{225, 275, 325, 375, 400, 400, 400};
        int nf = 0;
        int np = 0;
        bus.ENABLE  = 1'b1;
        bus.DESIRED = 20'd0;
        repeat (3) @(negedge CLK);
        chk("rst_pwm", 32'(bus.PWM), 0);
        chk("rst_frame", 32'(bus.FRAME), 0);
        chk("rst_flag", 32'(bus.FLAG), 0);
        chk("rst_current", 32'(bus.CURRENT), 0);
        RST = 1'b0;
        #1;
        frame("zero1", 100, 0, 1'b0, 0);
        frame("zero2", 100, 0, 1'b0, 1000);
        frame("zero3", 100, 0, 1'b1, 1000);
        bus.DESIRED = 20'd175;
        for (int i = 0; i < 4; i++) frame("ramp175", 100 + c175[i], c175[i], 1'b0, 1000);
        frame("settle175a", 275, 175, 1'b0, 1000);
        frame("settle175b", 275, 175, 1'b1, 1000);
        bus.DESIRED = 20'd999;
        for (int i = 0; i < 7; i++) frame("clamp", 100 + c400[i], c400[i], i == 6, 1000);
        chk("hold_flag", 32'(bus.FLAG), 1);
        bus.DESIRED = 20'd380;
        repeat (100) @(negedge CLK);
        bus.DESIRED = 20'd0;
        frame("retarget", 450, 350, 1'b0, 1000);
        wait_frame();
        repeat (20) @(negedge CLK);
        chk("pre_disable_pwm", 32'(bus.PWM), 1);
        chk("pre_disable_current", 32'(bus.CURRENT), 300);
        bus.ENABLE = 1'b0;
        @(negedge CLK);
        chk("disable_pwm", 32'(bus.PWM), 0);
        chk("disable_flag", 32'(bus.FLAG), 0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            nf += int'(bus.FRAME);
            np += int'(bus.PWM);
        end
        chk("disabled_frames", nf, 0);
        chk("disabled_pwm_cycles", np, 0);
        chk("disabled_current", 32'(bus.CURRENT), 300);
        bus.ENABLE = 1'b1;
        #1;
        chk("resume_frame_now", 32'(bus.FRAME), 1);
        frame("resume", 350, 250, 1'b0, 0);
        wait_frame();
        repeat (50) @(negedge CLK);
        chk("pre_rst_pwm", 32'(bus.PWM), 1);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_pwm", 32'(bus.PWM), 0);
        chk("midrst_current", 32'(bus.CURRENT), 0);
        chk("midrst_flag", 32'(bus.FLAG), 0);
        RST = 1'b0;
        #1;
        chk("post_rst_frame_now", 32'(bus.FRAME), 1);
        frame("post_rst1", 100, 0, 1'b0, 0);
        frame("post_rst2", 100, 0, 1'b0, 1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
